// File: rtl/mau_pkg.sv
// Shared types and constants for the M-stage memory access unit.
package mau_pkg;

  localparam logic [31:0] DM_LAST = 32'h0000_2fff;
  localparam logic [31:0] T0_BASE = 32'h0000_7f00;
  localparam logic [31:0] T1_BASE = 32'h0000_7f10;
  localparam logic [31:0] IO_BASE = 32'h0000_7f20;
  localparam logic [3:0]  CNT_OFS = 4'h8;
  localparam int          TIMEOUT_CYC = 16;

  localparam logic [31:0] TMR_WIN = 32'd12;
  localparam logic [31:0] IO_WIN  = 32'd4;

  typedef enum logic [2:0] {
    OP_W  = 3'b000,
    OP_BU = 3'b001,
    OP_B  = 3'b010,
    OP_HU = 3'b011,
    OP_H  = 3'b100
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  // Request captured at accept; drives the bus for the whole WAIT phase.
  typedef struct packed {
    logic        load;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// Bus side of the memory access unit: req/ack handshake towards the system bridge.
interface mem_access_unit_if;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (output bus_req, bus_addr, bus_be, bus_wdata,
                  input  bus_rdata, bus_ack);
  modport slave  (input  bus_req, bus_addr, bus_be, bus_wdata,
                  output bus_rdata, bus_ack);
endinterface

// File: rtl/mau_addr_check.sv
// Combinational legality check: op decode, alignment, region map and read-only timer COUNT.
module mau_addr_check
  import mau_pkg::*;
(
  input  logic        load_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] addr_i,
  input  logic        ov_i,
  output logic        illegal_o
);

  logic is_w, is_h, is_b, bad_op, misal;
  logic in_dm, in_t0, in_t1, in_io, in_dev, ro_hit;

  always_comb begin
    is_w   = (op_i == OP_W);
    is_b   = (op_i == OP_BU) || (op_i == OP_B);
    is_h   = (op_i == OP_HU) || (op_i == OP_H);
    bad_op = !(is_w || is_b || is_h);
    misal  = (is_w && (addr_i[1:0] != 2'b00)) || (is_h && addr_i[0]);

    in_dm  = (addr_i <= DM_LAST);
    in_t0  = (addr_i >= T0_BASE) && (addr_i < T0_BASE + TMR_WIN);
    in_t1  = (addr_i >= T1_BASE) && (addr_i < T1_BASE + TMR_WIN);
    in_io  = (addr_i >= IO_BASE) && (addr_i < IO_BASE + IO_WIN);
    in_dev = in_t0 || in_t1 || in_io;

    // Timer COUNT registers are free-running and cannot be written.
    ro_hit = !load_i && ((addr_i == T0_BASE + {28'd0, CNT_OFS}) ||
                         (addr_i == T1_BASE + {28'd0, CNT_OFS}));

    illegal_o = ov_i || bad_op || misal || !(in_dm || in_dev) ||
                (in_dev && !is_w) || ro_hit;
  end

endmodule

// File: rtl/mem_access_unit.sv
// M-stage load/store engine: address checks, lane alignment, req/ack bus cycle, load extension.
// Optional BUS_TIMEOUT_EN: abandon WAIT after TIMEOUT_CYC cycles and raise an address exception.
module mem_access_unit
  import mau_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  input  logic               req_load,
  input  logic [2:0]         req_op,
  input  logic [31:0]        req_addr,
  input  logic               req_ov,
  input  logic [31:0]        req_wdata,
  input  logic               flush,
  mem_access_unit_if.master  bus,
  output logic               stall,
  output logic               resp_valid,
  output logic [31:0]        rdata,
  output logic               exc_adel,
  output logic               exc_ades
);

  state_e      state_q, state_d;
  req_t        req_q, req_d;
  logic [31:0] rdata_q, rdata_d;
  logic        sup_q, sup_d;
  logic        illegal;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ext_data;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

`ifdef BUS_TIMEOUT_EN
  localparam logic [4:0] TO_LAST = 5'(TIMEOUT_CYC - 1);
  logic [4:0] cnt_q, cnt_d;
  logic       to_q, to_d;
`endif

  mau_addr_check u_chk (
    .load_i    (req_load),
    .op_i      (req_op),
    .addr_i    (req_addr),
    .ov_i      (req_ov),
    .illegal_o (illegal)
  );

  // Store lane placement: narrow data replicated so any enabled lane sees it.
  always_comb begin
    st_be    = 4'b0000;
    st_wdata = 32'd0;
    if (!req_load) begin
      case (req_op)
        OP_W:        begin st_be = 4'b1111; st_wdata = req_wdata; end
        OP_BU, OP_B: begin st_be = 4'b0001 << req_addr[1:0]; st_wdata = {4{req_wdata[7:0]}}; end
        OP_HU, OP_H: begin st_be = req_addr[1] ? 4'b1100 : 4'b0011; st_wdata = {2{req_wdata[15:0]}}; end
        default:     begin st_be = 4'b0000; st_wdata = 32'd0; end
      endcase
    end
  end

  always_comb begin
    lane_b   = bus.bus_rdata[{req_q.addr[1:0], 3'b000} +: 8];
    lane_h   = req_q.addr[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
    ext_data = bus.bus_rdata;
    case (req_q.op)
      OP_BU:   ext_data = {24'd0, lane_b};
      OP_B:    ext_data = {{24{lane_b[7]}}, lane_b};
      OP_HU:   ext_data = {16'd0, lane_h};
      OP_H:    ext_data = {{16{lane_h[15]}}, lane_h};
      default: ext_data = bus.bus_rdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    rdata_d    = rdata_q;
    sup_d      = sup_q;
    stall      = 1'b0;
    resp_valid = 1'b0;
    exc_adel   = 1'b0;
    exc_ades   = 1'b0;
`ifdef BUS_TIMEOUT_EN
    cnt_d      = cnt_q;
    to_d       = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid && !flush) begin
          if (illegal) begin
            exc_adel = req_load;
            exc_ades = !req_load;
          end else begin
            req_d.load  = req_load;
            req_d.op    = req_op;
            req_d.addr  = req_addr;
            req_d.be    = st_be;
            req_d.wdata = st_wdata;
            sup_d       = 1'b0;
            stall       = 1'b1;
            state_d     = WAIT;
`ifdef BUS_TIMEOUT_EN
            cnt_d       = 5'd0;
`endif
          end
        end
      end
      WAIT: begin
        stall = 1'b1;
        // A flushed store still has to commit; only the response is dropped.
        if (flush) sup_d = 1'b1;
        if (bus.bus_ack) begin
          if (req_q.load) rdata_d = ext_data;
          state_d = DONE;
        end
`ifdef BUS_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          state_d = IDLE;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
`endif
      end
      DONE: begin
        resp_valid = !sup_q && !flush;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef BUS_TIMEOUT_EN
    if (to_q && !flush) begin
      exc_adel = exc_adel || req_q.load;
      exc_ades = exc_ades || !req_q.load;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= '0;
      rdata_q <= 32'd0;
      sup_q   <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      cnt_q   <= 5'd0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      sup_q   <= sup_d;
`ifdef BUS_TIMEOUT_EN
      cnt_q   <= cnt_d;
      to_q    <= to_d;
`endif
    end
  end

  assign bus.bus_req   = (state_q == WAIT);
  assign bus.bus_addr  = {req_q.addr[31:2], 2'b00};
  assign bus.bus_be    = req_q.be;
  assign bus.bus_wdata = req_q.wdata;
  assign rdata         = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit against a transaction-level model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_load, req_ov, flush;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        stall, resp_valid, exc_adel, exc_ades;
  logic [31:0] rdata;

  int n_chk = 0;
  int n_fail = 0;

  mem_access_unit_if bif ();

  mem_access_unit dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_load   (req_load),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_ov     (req_ov),
    .req_wdata  (req_wdata),
    .flush      (flush),
    .bus        (bif.master),
    .stall      (stall),
    .resp_valid (resp_valid),
    .rdata      (rdata),
    .exc_adel   (exc_adel),
    .exc_ades   (exc_ades)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int op_size(input logic [2:0] op);
    if (op == 3'd0) return 4;
    if (op == 3'd1 || op == 3'd2) return 1;
    if (op == 3'd3 || op == 3'd4) return 2;
    return 0;
  endfunction

  function automatic bit exp_illegal(input bit ld, input logic [2:0] op,
                                     input logic [31:0] a, input bit ov);
    int sz;
    bit dev;
    sz = op_size(op);
    if (ov || sz == 0) return 1'b1;
    if ((int'(a[1:0]) % sz) != 0) return 1'b1;
    dev = (a >= 32'h7f00 && a < 32'h7f0c) || (a >= 32'h7f10 && a < 32'h7f1c) ||
          (a >= 32'h7f20 && a < 32'h7f24);
    if (dev && sz != 4) return 1'b1;
    if (!ld && (a == 32'h7f08 || a == 32'h7f18)) return 1'b1;
    return !(a <= 32'h2fff || dev);
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * int'(a[1:0]))) & 32'hff;
    h = (rd >> (16 * int'(a[1]))) & 32'hffff;
    case (op)
      3'd1:    return b;
      3'd2:    return (b >= 32'h80) ? (b | 32'hffff_ff00) : b;
      3'd3:    return h;
      3'd4:    return (h >= 32'h8000) ? (h | 32'hffff_0000) : h;
      default: return rd;
    endcase
  endfunction

  function automatic logic [3:0] exp_be(input bit ld, input logic [2:0] op, input logic [31:0] a);
    if (ld) return 4'b0000;
    case (op_size(op))
      1:       return 4'(1 << int'(a[1:0]));
      2:       return (a[1:0] == 2'd2) ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] exp_wd(input logic [2:0] op, input logic [31:0] w);
    case (op_size(op))
      1:       return (w & 32'hff) * 32'h0101_0101;
      2:       return (w & 32'hffff) * 32'h0001_0001;
      default: return w;
    endcase
  endfunction

  // One access from IDLE. delay = extra WAIT cycles before ack; flush_at = WAIT cycle
  // index that sees flush (-1: none); fd = flush during the response cycle.
  task automatic access(input bit ld, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] wd, input bit ov, input int delay,
                        input logic [31:0] rd, input int flush_at, input bit fd);
    bit ill, flushed;
    int stalls;
    ill = exp_illegal(ld, op, a, ov);
    req_valid = 1'b1; req_load = ld; req_op = op; req_addr = a;
    req_wdata = wd; req_ov = ov;
    @(negedge clk);
    chk("exc_adel", {31'd0, exc_adel}, {31'd0, ill && ld});
    chk("exc_ades", {31'd0, exc_ades}, {31'd0, ill && !ld});
    chk("stall_accept", {31'd0, stall}, {31'd0, !ill});
    stalls = stall ? 1 : 0;
    @(posedge clk); #1;
    if (ill) begin
      req_valid = 1'b0;
      @(negedge clk);
      chk("no_bus_req_on_exc", {31'd0, bif.bus_req}, 32'd0);
      chk("stall_after_exc", {31'd0, stall}, 32'd0);
      @(posedge clk); #1;
      return;
    end
    for (int i = 0; i <= delay; i++) begin
      bif.bus_ack   = (i == delay);
      bif.bus_rdata = (i == delay) ? rd : $urandom;
      flush         = (i == flush_at);
      @(negedge clk);
      chk("bus_req_wait", {31'd0, bif.bus_req}, 32'd1);
      chk("stall_wait", {31'd0, stall}, 32'd1);
      chk("bus_addr", bif.bus_addr, a & 32'hffff_fffc);
      chk("bus_be", {28'd0, bif.bus_be}, {28'd0, exp_be(ld, op, a)});
      if (!ld) chk("bus_wdata", bif.bus_wdata, exp_wd(op, wd));
      if (stall) stalls++;
      @(posedge clk); #1;
    end
    bif.bus_ack = 1'b0;
    flushed = (flush_at >= 0) && (flush_at <= delay);
    flush = fd;
    @(negedge clk);
    chk("resp_valid", {31'd0, resp_valid}, {31'd0, !flushed && !fd});
    chk("stall_done", {31'd0, stall}, 32'd0);
    chk("bus_req_done", {31'd0, bif.bus_req}, 32'd0);
    chk("stall_count", stalls, delay + 2);
    if (ld && !flushed && !fd) chk("rdata", rdata, exp_load(op, a, rd));
    @(posedge clk); #1;
    flush = 1'b0;
    req_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom % 6)
      0:       return $urandom % 32'h3000;
      1:       return 32'h7f00 + ($urandom % 16);
      2:       return 32'h7f10 + ($urandom % 16);
      3:       return 32'h7f20 + ($urandom % 8);
      4:       return 32'h2ff0 + ($urandom % 32);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_load = 1'b0; req_op = 3'd0; req_addr = 32'd0;
    req_ov = 1'b0; req_wdata = 32'd0; flush = 1'b0;
    bif.bus_ack = 1'b0; bif.bus_rdata = 32'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_bus_req", {31'd0, bif.bus_req}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_exc", {30'd0, exc_adel, exc_ades}, 32'd0);
    chk("rst_bus_be", {28'd0, bif.bus_be}, 32'd0);
    @(posedge clk); #1;

    // Directed cases
    access(1, 3'd0, 32'h0000_0010, 32'd0, 0, 2, 32'h8765_4321, -1, 0);
    access(1, 3'd2, 32'h0000_0003, 32'd0, 0, 0, 32'h80FF_FFFF, -1, 0);
    access(1, 3'd1, 32'h0000_0003, 32'd0, 0, 0, 32'h80FF_FFFF, -1, 0);
    access(0, 3'd3, 32'h0000_0102, 32'h0000_BEEF, 0, 1, 32'd0, -1, 0);
    access(0, 3'd1, 32'h0000_0201, 32'h1234_56A5, 0, 0, 32'd0, -1, 0);
    access(1, 3'd4, 32'h0000_0206, 32'd0, 0, 1, 32'h9abc_0000, -1, 0);
    access(1, 3'd3, 32'h0000_7f04, 32'd0, 0, 0, 32'd0, -1, 0);
    access(0, 3'd0, 32'h0000_7f18, 32'h1, 0, 0, 32'd0, -1, 0);
    access(1, 3'd0, 32'h0000_3000, 32'd0, 0, 0, 32'd0, -1, 0);
    access(1, 3'd0, 32'h0000_0002, 32'd0, 0, 0, 32'd0, -1, 0);
    access(1, 3'd5, 32'h0000_0000, 32'd0, 0, 0, 32'd0, -1, 0);
    access(0, 3'd0, 32'h0000_0004, 32'd0, 1, 0, 32'd0, -1, 0);
    access(1, 3'd0, 32'h0000_7f08, 32'd0, 0, 0, 32'h0000_1234, -1, 0);
    access(0, 3'd0, 32'h0000_0040, 32'hCAFE_F00D, 0, 2, 32'd0, 0, 0);
    access(1, 3'd0, 32'h0000_0044, 32'd0, 0, 1, 32'h1111_2222, 1, 0);
    access(1, 3'd0, 32'h0000_0048, 32'd0, 0, 0, 32'h3333_4444, -1, 1);

    // Flush in IDLE hides the exception and accepts nothing
    req_valid = 1'b1; req_load = 1'b1; req_op = 3'd0; req_addr = 32'h0000_0002; flush = 1'b1;
    @(negedge clk);
    chk("flush_idle_exc", {30'd0, exc_adel, exc_ades}, 32'd0);
    chk("flush_idle_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_idle_no_req", {31'd0, bif.bus_req}, 32'd0);
    @(posedge clk); #1;

    // Reset in WAIT abandons the bus cycle
    req_valid = 1'b1; req_load = 1'b1; req_op = 3'd0; req_addr = 32'h0000_0080; req_ov = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst_wait_req", {31'd0, bif.bus_req}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_wait_drop", {31'd0, bif.bus_req}, 32'd0);
    @(posedge clk); #1;

`ifdef BUS_TIMEOUT_EN
    req_valid = 1'b1; req_load = 1'b1; req_op = 3'd0; req_addr = 32'h0000_0020;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("to_bus_req", {31'd0, bif.bus_req}, 32'd1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("to_drop", {31'd0, bif.bus_req}, 32'd0);
    chk("to_adel", {31'd0, exc_adel}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("to_adel_once", {31'd0, exc_adel}, 32'd0);
    @(posedge clk); #1;
`endif

    // Random traffic
    for (int n = 0; n < 80; n++) begin
      bit ld, ov, fd;
      logic [2:0] op;
      int dly, fa;
      ld  = 1'($urandom % 2);
      op  = 3'($urandom % 6);
      ov  = (($urandom % 16) == 0);
      dly = $urandom % 4;
      fa  = (($urandom % 5) == 0) ? int'($urandom % (dly + 1)) : -1;
      fd  = (($urandom % 8) == 0);
      access(ld, op, rand_addr(), $urandom, ov, dly, $urandom, fa, fd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
